// File: rtl/axi_master_arbiter.sv
// Round-robin arbiter sharing one axi_master command port among NUM_REQ requesters.
// Grant to start pulse is 1 cycle and done to rsp_valid is 1 cycle; requesters hold req_valid until req_ready pulses.
module axi_master_arbiter #(
  parameter int NUM_REQ            = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                                    M_AXI_ACLK,
  input  logic                                    M_AXI_ARESETN,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ-1:0]                      req_write,
  input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*C_M_AXI_DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                      req_ready,
  output logic [NUM_REQ-1:0]                      rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]           rsp_rdata,
  output logic                                    rsp_err,
  output logic                                    busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]           addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0]           write_data,
  output logic                                    start_write,
  output logic                                    start_read,
  input  logic                                    done,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]           read_data
);
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [GW-1:0] GRANT_INIT = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     grant, grant_nxt;
  logic [GW-1:0]     last_grant, last_grant_nxt;
  logic              wr_flag, wr_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [AW-1:0]     addr_nxt;
  logic [DW-1:0]     wdata_nxt, rdata_nxt;
  logic              start_write_nxt, start_read_nxt, err_nxt, busy_nxt;
  logic [NUM_REQ-1:0] ready_nxt, rspv_nxt;
  logic              found;
  logic [GW-1:0]     pick, cand;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= GRANT_INIT;
      wr_flag     <= 1'b0;
      cnt         <= '0;
      addr        <= '0;
      write_data  <= '0;
      start_write <= 1'b0;
      start_read  <= 1'b0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      last_grant  <= last_grant_nxt;
      wr_flag     <= wr_nxt;
      cnt         <= cnt_nxt;
      addr        <= addr_nxt;
      write_data  <= wdata_nxt;
      start_write <= start_write_nxt;
      start_read  <= start_read_nxt;
      req_ready   <= ready_nxt;
      rsp_valid   <= rspv_nxt;
      rsp_rdata   <= rdata_nxt;
      rsp_err     <= err_nxt;
      busy        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    last_grant_nxt  = last_grant;
    wr_nxt          = wr_flag;
    cnt_nxt         = cnt;
    addr_nxt        = addr;
    wdata_nxt       = write_data;
    rdata_nxt       = rsp_rdata;
    err_nxt         = rsp_err;
    start_write_nxt = 1'b0;
    start_read_nxt  = 1'b0;
    ready_nxt       = '0;
    rspv_nxt        = '0;
    found           = 1'b0;
    pick            = '0;
    cand            = '0;

    // Search upward from last_grant+1 with wrap; the last grant gets lowest priority.
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = GW'((int'(last_grant) + off) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    // Outputs are registered, so pulses for the next state are computed here.
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt       = pick;
          addr_nxt        = req_addr[int'(pick)*AW +: AW];
          wdata_nxt       = req_wdata[int'(pick)*DW +: DW];
          wr_nxt          = req_write[pick];
          ready_nxt[pick] = 1'b1;
          start_write_nxt = req_write[pick];
          start_read_nxt  = !req_write[pick];
          state_nxt       = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (done) begin
          rdata_nxt       = wr_flag ? '0 : read_data;
          err_nxt         = 1'b0;
          rspv_nxt[grant] = 1'b1;
          state_nxt       = RESP;
        end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
          rdata_nxt       = '0;
          err_nxt         = 1'b1;
          rspv_nxt[grant] = 1'b1;
          state_nxt       = RESP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RESP: begin
        last_grant_nxt = grant;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end
endmodule

// File: doc/axi_master_arbiter.md
# axi_master_arbiter

Round-robin arbiter that shares one `axi_master` command port (`addr`, `write_data`, `start_read`, `start_write`, `done`, `read_data`) between `NUM_REQ` independent requesters. The block sits between the requester logic (button/LED sequencers, DFR configuration engines) and `axi_master`. It serialises single-beat read and write commands and routes each completion back to the requester that issued it. A watchdog aborts transactions whose `done` never arrives.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `C_M_AXI_DATA_WIDTH`, 32: data width (DW).
- `C_M_AXI_ADDR_WIDTH`, 32: address width (AW).
- `TIMEOUT_CYCLES`, 1024: watchdog limit in WAIT. A value of 0 disables the watchdog.

Ports:
- `M_AXI_ACLK` in 1: sole clock, rising edge.
- `M_AXI_ARESETN` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: requester i holds a pending command.
- `req_write` in NUM_REQ: 1 = write, 0 = read, per requester.
- `req_addr` in NUM_REQ*AW: packed addresses; requester i occupies bits [i*AW +: AW].
- `req_wdata` in NUM_REQ*DW: packed write data; requester i occupies bits [i*DW +: DW].
- `req_ready` out NUM_REQ: one-cycle pulse meaning the command from requester i was accepted.
- `rsp_valid` out NUM_REQ: one-cycle completion pulse to requester i.
- `rsp_rdata` out DW: read data, valid only while a `rsp_valid` bit is high.
- `rsp_err` out 1: timeout flag, valid only while a `rsp_valid` bit is high.
- `busy` out 1: high in every state other than IDLE.
- `addr` out AW: command address to `axi_master`.
- `write_data` out DW: write data to `axi_master`.
- `start_write` out 1: one-cycle start pulse to `axi_master`.
- `start_read` out 1: one-cycle start pulse to `axi_master`.
- `done` in 1: completion pulse from `axi_master`.
- `read_data` in DW: read data from `axi_master`, valid with `done`.

## Operation

States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.

- **IDLE**
  - If any `req_valid` bit is set, select grant index g as the first set bit searching upward (with wrap) from `last_grant+1`.
  - Latch `req_addr[g]` into `addr`, `req_wdata[g]` into `write_data`, and `req_write[g]` into the internal write flag. Go to ISSUE.
  - Otherwise remain in IDLE.
- **ISSUE** (exactly 1 cycle)
  - `req_ready[g]`=1.
  - `start_write`=1 if the latched write flag is 1; otherwise `start_read`=1.
  - Clear the watchdog counter. Go to WAIT.
- **WAIT**
  - On `done`: `rsp_rdata` ← `read_data` for a read, 0 for a write. `rsp_err` ← 0. Go to RESP.
  - Otherwise, when `TIMEOUT_CYCLES` is nonzero and the counter reaches `TIMEOUT_CYCLES`-1: `rsp_rdata` ← 0, `rsp_err` ← 1, go to RESP.
  - Otherwise increment the counter.
- **RESP** (exactly 1 cycle)
  - `rsp_valid[g]`=1.
  - `last_grant` ← g. Go to IDLE.

Rules:
- Requester i must hold `req_valid[i]`, `req_write[i]`, `req_addr[i]` and `req_wdata[i]` stable until it sees `req_ready[i]`.
- A requester that drops `req_valid` before its grant is simply skipped. The block never issues a command without `req_valid` set at the IDLE sampling edge.
- `done` is ignored in IDLE, ISSUE and RESP. This covers late completions after a timeout and spurious pulses.
- `addr` and `write_data` hold their latched values until the next grant.
- At most one `req_ready` bit, one `rsp_valid` bit and one start pulse are high in any cycle.
- Fairness: a requester with `req_valid` held high is granted within NUM_REQ transactions.
- The watchdog counter is wide enough to represent TIMEOUT_CYCLES.

## Timing

Reset:
- While `M_AXI_ARESETN`=0, immediately (asynchronously): state=IDLE, `last_grant`=NUM_REQ-1 (so requester 0 wins first), watchdog counter=0.
- All outputs = 0: `addr`, `write_data`, `start_*`, `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `busy`.
- Reset mid-transaction abandons it. No `rsp_valid` is produced for the abandoned command.

Latency:
- `req_valid` sampled at edge 0 → `req_ready` and the start pulse are high in cycle 1 → WAIT from cycle 2.
- `done` sampled at edge k → `rsp_valid` high in cycle k+1.
- The next grant is sampled at edge k+2 at the earliest.
- Minimum per-transaction overhead is 3 cycles plus the `axi_master` latency.

Simultaneous events:
- A new `req_valid` arriving during WAIT or RESP waits for IDLE.
- A requester may reassert `req_valid` in the same cycle as its `rsp_valid`. It competes normally, with round-robin priority applied.

## Test plan

1. **Reset values.**
   - Stimulus: hold reset with every `req_valid`=1.
   - Required: every output = 0 and `busy`=0. One cycle after release: `req_ready[0]` and the start pulse are high.
2. **Single write.**
   - Stimulus: requester 2 writes `addr`=0x10, data=0xA5; `done` arrives 5 cycles after `start_write`.
   - Required: `start_write` is a 1-cycle pulse with `addr`=0x10 and `write_data`=0xA5. `rsp_valid`=0b0100 one cycle after `done`, with `rsp_err`=0 and `rsp_rdata`=0.
3. **Read return.**
   - Stimulus: requester 1 reads 0x4; the model returns `read_data`=0xDEADBEEF with `done`.
   - Required: `rsp_valid[1]`=1 and `rsp_rdata`=0xDEADBEEF in the same cycle.
4. **Round-robin fairness.**
   - Stimulus: all 4 requesters hold `req_valid` continuously for 8 transactions.
   - Required: grant order 0,1,2,3,0,1,2,3, with no grant given twice in a row.
5. **Timeout.**
   - Stimulus: `TIMEOUT_CYCLES`=16; the model never asserts `done`, then pulses `done` 5 cycles after the response.
   - Required: `rsp_valid` is asserted with `rsp_err`=1 and `rsp_rdata`=0, 17 cycles after the start pulse. The late `done` is ignored; no extra `rsp_valid` and no state change.
6. **Reset mid-WAIT.**
   - Stimulus: assert reset for 2 cycles while in WAIT.
   - Required: outputs clear immediately and no `rsp_valid` is emitted. After release, the pending requester is granted first in round-robin order from requester 0.
